seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving operand and result width; legal values are even integers from 8 to 64.
REQ-002 SHALL have parameter MUL_EN, default 1; when set, the multi-cycle multiply op is enabled.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  request present.
REQ-006 SHALL have port in_ready  out  1  request accepted on this edge if in_valid is also high.
REQ-007 SHALL have port a  in  WIDTH  signed operand A.
REQ-008 SHALL have port b  in  WIDTH  signed operand B.
REQ-009 SHALL have port op  in  5  operation code.
REQ-010 SHALL have port out_valid  out  1  result present.
REQ-011 SHALL have port out_ready  in  1  consumer takes the result.
REQ-012 SHALL have port c  out  WIDTH  result.
REQ-013 SHALL have port cout  out  1  signed overflow.
REQ-014 SHALL have port bcond  out  1  branch condition.
REQ-015 SHALL have port zero  out  1  c equals 0.
REQ-016 SHALL have port err  out  1  illegal op code.

Function
REQ-017 SHALL implement states IDLE, BUSY and DONE.
REQ-018 SHALL drive in_ready high when the state is IDLE, or when the state is DONE and out_ready is high (back-to-back acceptance); otherwise in_ready SHALL be low.
REQ-019 SHALL compute ops 0-15 in one cycle: an accept moves the state to DONE and registers the result, so out_valid is high on the edge after the accept (latency 1).
REQ-020 SHALL implement op codes 0-7 as: 0 ADD a+b; 1 SUB a-b; 2 NAND; 3 NOR; 4 XNOR; 5 AND; 6 OR; 7 XOR.
REQ-021 SHALL implement op codes 8-15 as:
- 8 pass a; 9 ~a; 10 arithmetic shift right by 1; 11 logical shift right by 1
- 12 two's-complement negate of a; 13 shift left by 1; 14 rotate left by 1
- 15 {b[WIDTH/2-1:0], WIDTH/2 zeros}
REQ-022 SHALL implement op 16 (MUL, when MUL_EN=1) as a signed multiply returning the low WIDTH bits, using an iterative shift-add over exactly WIDTH BUSY cycles.
REQ-023 SHALL, for MUL, have out_valid rise WIDTH+1 edges after the accept.
REQ-024 SHALL keep in_ready low during BUSY and ignore in_valid while in BUSY.
REQ-025 SHALL move from BUSY to DONE after the last iteration.
REQ-026 SHALL treat op 17-31, and op 16 when MUL_EN=0, as illegal: the state goes to DONE with c=0, err=1 and all other flags 0.
REQ-027 SHALL set cout to 1 on signed overflow for ADD (same operand signs, result sign differs) and for SUB (operand signs differ, result sign differs from a); cout SHALL be 0 for every other op.
REQ-028 SHALL set bcond to 1 only for SUB when the result is nonzero (a != b); bcond SHALL be 0 otherwise.
REQ-029 SHALL set zero to 1 when the registered c is all zeros, for every legal op.
REQ-030 SHALL hold c, cout, bcond, zero and err stable while in DONE with out_ready low.
REQ-031 SHALL, in DONE with out_ready high and no new accept, go to IDLE and clear out_valid.
REQ-032 SHALL, in DONE when out_ready and in_valid are both high on the same edge, retire the old result and accept the new request on that edge with no bubble.
REQ-033 SHALL wrap all arithmetic modulo 2^WIDTH; negate of the most negative value SHALL return the same value with cout=0.

Reset
REQ-034 SHALL, while reset_n is low, immediately force the state to IDLE, out_valid=0, c=0, cout=0, bcond=0, zero=0 and err=0, independent of clk.
REQ-035 SHALL, if reset is asserted during BUSY, abandon the multiply; no result SHALL appear after release.
REQ-036 SHALL drive in_ready high during reset and on the first edge after reset_n rises.

Verification
REQ-037 ADD with WIDTH=16, a=16'h7FFF, b=16'h0001 -> one edge later c=16'h8000, cout=1, zero=0, out_valid=1.
REQ-038 SUB with a=b=16'h1234 -> c=0, zero=1, bcond=0; then a=5, b=3 -> c=2, bcond=1.
REQ-039 MUL with a=-3, b=7 (WIDTH=16) -> out_valid exactly 17 edges after the accept, c=16'hFFEB; in_ready low throughout BUSY.
REQ-040 Back-to-back ops 15 then 14, with out_ready held high and b=16'h00AB, a=16'h8001 -> c=16'hAB00 then c=16'h0003 on consecutive cycles.
REQ-041 op=20 -> err=1, c=0; holding out_ready low for 5 cycles keeps all outputs unchanged.
REQ-042 reset_n pulsed low in the 8th cycle of a MUL -> outputs clear asynchronously, out_valid stays 0 after release, and in_ready=1.

Source files
------------

// File: rtl/seq_alu.sv
// Purpose: sequential ALU with 16 one-cycle ops plus an optional iterative signed multiply.
// Latency: 1 cycle for ops 0-15 and illegal ops; WIDTH+1 cycles for MUL (WIDTH BUSY cycles).
// Backpressure: result held in DONE until out_ready; a new request may be accepted on the retiring edge.
// Ports: clk/reset_n (async active-low); in_valid/in_ready + a, b, op request side;
//        out_valid/out_ready + c, cout (signed overflow), bcond (SUB nonzero), zero, err (illegal op).
module seq_alu #(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             cout,
    output logic             bcond,
    output logic             zero,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q;
    logic             cout_q, bcond_q, zero_q, err_q;

    // Multiply datapath: acc accumulates mcand shifted left once per step
    // whenever the current low bit of mplier is set.
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, acc_nxt;
    logic [CW-1:0]    cnt_q;

    logic             accept, is_mul;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_c;
    logic             alu_cout, alu_bcond, alu_err;

    assign is_mul    = (MUL_EN != 0) && (op == 5'd16);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);

    assign c     = c_q;
    assign cout  = cout_q;
    assign bcond = bcond_q;
    assign zero  = zero_q;
    assign err   = err_q;

    assign sum     = a + b;
    assign diff    = a - b;
    assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Single-cycle result. Anything with op[4] set other than an enabled MUL is illegal.
    always_comb begin
        alu_c     = '0;
        alu_cout  = 1'b0;
        alu_bcond = 1'b0;
        alu_err   = 1'b0;
        if (op[4]) begin
            alu_err = !is_mul;
        end else begin
            case (op[3:0])
                4'd0: begin
                    alu_c    = sum;
                    alu_cout = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                4'd1: begin
                    alu_c     = diff;
                    alu_cout  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                    alu_bcond = (diff != '0);
                end
                4'd2:    alu_c = ~(a & b);
                4'd3:    alu_c = ~(a | b);
                4'd4:    alu_c = ~(a ^ b);
                4'd5:    alu_c = a & b;
                4'd6:    alu_c = a | b;
                4'd7:    alu_c = a ^ b;
                4'd8:    alu_c = a;
                4'd9:    alu_c = ~a;
                4'd10:   alu_c = $signed(a) >>> 1;
                4'd11:   alu_c = a >> 1;
                4'd12:   alu_c = '0 - a;  // most negative value wraps to itself
                4'd13:   alu_c = a << 1;
                4'd14:   alu_c = {a[WIDTH-2:0], a[WIDTH-1]};
                default: alu_c = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = is_mul ? BUSY : DONE;
            end
            BUSY: begin
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                // Retiring and accepting on the same edge keeps the pipe bubble-free.
                if (out_ready) begin
                    if (in_valid) state_d = is_mul ? BUSY : DONE;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_q      <= '0;
            cout_q   <= 1'b0;
            bcond_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            if (is_mul) begin
                acc_q    <= '0;
                mcand_q  <= a;
                mplier_q <= b;
                cnt_q    <= '0;
            end else begin
                c_q     <= alu_c;
                cout_q  <= alu_cout;
                bcond_q <= alu_bcond;
                err_q   <= alu_err;
                zero_q  <= !alu_err && (alu_c == '0);
            end
        end else if (state_q == BUSY) begin
            // Low WIDTH bits of the unsigned shift-add equal the signed product mod 2^WIDTH.
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                c_q     <= acc_nxt;
                cout_q  <= 1'b0;
                bcond_q <= 1'b0;
                err_q   <= 1'b0;
                zero_q  <= (acc_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [4:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic         cout, bcond, zero, err;

    seq_alu #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .cout(cout), .bcond(bcond), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] c;
        logic         cout, bcond, zero, err;
        int           ready;
    } exp_t;

    exp_t q[$];

    // Reference: integer arithmetic on the signed operand values.
    function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t r;
        int sa, sb, ua, full;
        sa = int'($signed(x));
        sb = int'($signed(y));
        ua = int'(x);
        r.c = '0; r.cout = 0; r.bcond = 0; r.err = 0; r.ready = 0;
        case (o)
            5'd0: begin full = sa + sb; r.c = full[W-1:0]; r.cout = (full > 32767) || (full < -32768); end
            5'd1: begin full = sa - sb; r.c = full[W-1:0]; r.cout = (full > 32767) || (full < -32768);
                        r.bcond = (x != y); end
            5'd2:  r.c = ~(x & y);
            5'd3:  r.c = ~(x | y);
            5'd4:  r.c = ~(x ^ y);
            5'd5:  r.c = x & y;
            5'd6:  r.c = x | y;
            5'd7:  r.c = x ^ y;
            5'd8:  r.c = x;
            5'd9:  r.c = ~x;
            5'd10: begin full = sa >>> 1; r.c = full[W-1:0]; end
            5'd11: begin full = ua / 2; r.c = full[W-1:0]; end
            5'd12: begin full = -sa; r.c = full[W-1:0]; end
            5'd13: begin full = ua * 2; r.c = full[W-1:0]; end
            5'd14: begin full = ua * 2 + ua / 32768; r.c = full[W-1:0]; end
            5'd15: begin full = (int'(y) % 256) * 256; r.c = full[W-1:0]; end
            5'd16: begin full = sa * sb; r.c = full[W-1:0]; end
            default: r.err = 1;
        endcase
        r.zero = !r.err && (r.c == 0);
        return r;
    endfunction

    // One compare process: checks handshake and result fields every cycle.
    always @(negedge clk) begin
        logic exp_ov, exp_ir;
        exp_t e;
        if (!reset_n) begin
            q.delete();
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_c", c, 0);
            check("rst_flags", {cout, bcond, zero, err}, 0);
        end else begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].ready);
            exp_ir = (q.size() == 0) || (exp_ov && out_ready);
            check("out_valid", out_valid, exp_ov);
            check("in_ready", in_ready, exp_ir);
            if (exp_ov) begin
                check("c", c, q[0].c);
                check("cout", cout, q[0].cout);
                check("bcond", bcond, q[0].bcond);
                check("zero", zero, q[0].zero);
                check("err", err, q[0].err);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && exp_ir) begin
                e = model(op, a, b);
                e.ready = cyc + 1 + ((op == 5'd16) ? W : 0);
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (q.size() == 0) return;
        end
        check("drain_timeout", 1, 0);
    endtask

    logic [W-1:0] vec_a [4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFD};
    logic [W-1:0] vec_b [4] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0007};

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_in_ready", in_ready, 1);

        // ADD overflow.
        out_ready = 1'b1;
        send(5'd0, 16'h7FFF, 16'h0001);
        check("add_valid", out_valid, 1);
        check("add_c", c, 16'h8000);
        check("add_cout", cout, 1);
        check("add_zero", zero, 0);

        // SUB equal then unequal.
        send(5'd1, 16'h1234, 16'h1234);
        check("sub_eq_c", c, 0);
        check("sub_eq_zero", zero, 1);
        check("sub_eq_bcond", bcond, 0);
        send(5'd1, 16'd5, 16'd3);
        check("sub_c", c, 2);
        check("sub_bcond", bcond, 1);
        drain();

        // MUL -3 * 7: in_ready low and requests ignored through BUSY.
        send(5'd16, 16'hFFFD, 16'h0007);
        for (int k = 1; k < W; k++) begin
            if (k <= 10) begin in_valid = 1'b1; op = 5'd0; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
            check("mul_busy_in_ready", in_ready, 0);
            check("mul_busy_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mul_valid", out_valid, 1);
        check("mul_c", c, 16'hFFEB);
        drain();

        // Back-to-back op 15 then op 14.
        op = 5'd15; a = 16'h8001; b = 16'h00AB; in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_c0", c, 16'hAB00);
        check("b2b_v0", out_valid, 1);
        op = 5'd14;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_c1", c, 16'h0003);
        check("b2b_v1", out_valid, 1);
        drain();

        // Illegal op held under backpressure.
        out_ready = 1'b0;
        send(5'd20, 16'h1111, 16'h2222);
        for (int k = 0; k < 5; k++) begin
            check("ill_valid", out_valid, 1);
            check("ill_err", err, 1);
            check("ill_c", c, 0);
            check("ill_flags", {cout, bcond, zero}, 0);
            @(posedge clk); #1;
        end
        drain();

        // Reset in the 8th BUSY cycle of a multiply.
        send(5'd0, 16'd1, 16'd1);
        send(5'd16, 16'd3, 16'd5);
        repeat (7) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_c", c, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", in_ready, 1);
        repeat (25) begin
            @(posedge clk); #1;
            check("rel_out_valid", out_valid, 0);
        end

        // Sweep all op codes over corner operands with random backpressure.
        for (int o = 0; o < 32; o++) begin
            if (o > 20 && o != 31) continue;
            for (int v = 0; v < 4; v++) begin
                out_ready = 1'($urandom_range(0, 1));
                send(5'(o), vec_a[v], vec_b[v]);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                drain();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
